// File: rtl/shift_pkg.sv
// Shared types and constants for the shift_arbiter slice: operand widths,
// controller states and shift-direction encodings.
package shift_pkg;

    localparam int WIDTH = 4;
    localparam int AMT_W = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/shift_arbiter_if.sv
// Bundle of the two requester handshakes and the external shifter datapath
// connection; slave is the controller side, master the clients/shifter side.
interface shift_arbiter_if;
    import shift_pkg::*;

    // req is held until the matching one-cycle gnt; operands are stable while
    // req is high; done marks the single cycle in which res belongs to that
    // requester.
    logic             req0, req1;
    logic [WIDTH-1:0] data0, data1;
    logic [AMT_W-1:0] amt0, amt1;
    logic             dir0, dir1;
    logic             gnt0, gnt1;
    logic             done0, done1;
    logic [WIDTH-1:0] res;
    logic             busy;
    logic [WIDTH-1:0] sh_data;
    logic [AMT_W-1:0] sh_amt;
    logic             sh_dir;
    logic [WIDTH-1:0] sh_res;

    modport slave (
        input  req0, req1, data0, data1, amt0, amt1, dir0, dir1, sh_res,
        output gnt0, gnt1, done0, done1, res, busy, sh_data, sh_amt, sh_dir
    );

    modport master (
        output req0, req1, data0, data1, amt0, amt1, dir0, dir1, sh_res,
        input  gnt0, gnt1, done0, done1, res, busy, sh_data, sh_amt, sh_dir
    );

endinterface

// File: rtl/shift_arbiter_rr_arb2.sv
// Two-input round-robin arbiter: a lone request wins outright, a tie goes
// to the requester named by prio_i.
module rr_arb2 (
    input  logic [1:0] req_i,
    input  logic       prio_i,
    input  logic       en_i,
    output logic       sel_o,
    output logic       valid_o
);

    always_comb begin
        valid_o = en_i & (|req_i);
        sel_o   = (&req_i) ? prio_i : req_i[1];
    end

endmodule

// File: rtl/shift_arbiter.sv
// Sequencing controller sharing one external barrel shifter between two
// requesters: arbitrate, load operands, capture result, pulse done.
module shift_arbiter
    import shift_pkg::*;
(
    input  logic              CLK,
    input  logic              RST,
    shift_arbiter_if.slave    bus_if,
    output state_e            state_o
);

    state_e           state_q, state_d;
    logic             prio_q, prio_d;
    logic             sel_q, sel_d;
    logic [WIDTH-1:0] sh_data_q, sh_data_d;
    logic [AMT_W-1:0] sh_amt_q, sh_amt_d;
    logic             sh_dir_q, sh_dir_d;
    logic [WIDTH-1:0] res_q, res_d;

    logic arb_sel, arb_valid;

    rr_arb2 u_arb (
        .req_i   ({bus_if.req1, bus_if.req0}),
        .prio_i  (prio_q),
        .en_i    (state_q == IDLE),
        .sel_o   (arb_sel),
        .valid_o (arb_valid)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= IDLE;
            prio_q    <= 1'b0;
            sel_q     <= 1'b0;
            sh_data_q <= '0;
            sh_amt_q  <= '0;
            sh_dir_q  <= DIR_LEFT;
            res_q     <= '0;
        end else begin
            state_q   <= state_d;
            prio_q    <= prio_d;
            sel_q     <= sel_d;
            sh_data_q <= sh_data_d;
            sh_amt_q  <= sh_amt_d;
            sh_dir_q  <= sh_dir_d;
            res_q     <= res_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        prio_d    = prio_q;
        sel_d     = sel_q;
        sh_data_d = sh_data_q;
        sh_amt_d  = sh_amt_q;
        sh_dir_d  = sh_dir_q;
        res_d     = res_q;
        unique case (state_q)
            IDLE: begin
                if (arb_valid) begin
                    state_d   = EXEC;
                    sel_d     = arb_sel;
                    sh_data_d = arb_sel ? bus_if.data1 : bus_if.data0;
                    sh_amt_d  = arb_sel ? bus_if.amt1  : bus_if.amt0;
                    sh_dir_d  = arb_sel ? bus_if.dir1  : bus_if.dir0;
                end
            end
            EXEC: begin
                // Operands have been stable for a full cycle; capture now.
                res_d   = bus_if.sh_res;
                state_d = RESP;
            end
            RESP: begin
                state_d = IDLE;
                prio_d  = ~sel_q;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus_if.gnt0    = (state_q == EXEC) && !sel_q;
    assign bus_if.gnt1    = (state_q == EXEC) &&  sel_q;
    assign bus_if.done0   = (state_q == RESP) && !sel_q;
    assign bus_if.done1   = (state_q == RESP) &&  sel_q;
    assign bus_if.busy    = (state_q != IDLE);
    assign bus_if.res     = res_q;
    assign bus_if.sh_data = sh_data_q;
    assign bus_if.sh_amt  = sh_amt_q;
    assign bus_if.sh_dir  = sh_dir_q;
    assign state_o        = state_q;

endmodule

// File: tb/tb_shift_arbiter.sv
// Self-checking bench for shift_arbiter: directed scenarios with literal
// expectations plus randomized two-requester traffic against a transaction model.
module tb_shift_arbiter;
  import shift_pkg::*;

  // ---------------- clock / reset ----------------
  logic CLK = 1'b0;
  logic RST = 1'b0;
  always #5 CLK = ~CLK;

  shift_arbiter_if bus();
  state_e dbg_state;

  shift_arbiter dut (
    .CLK     (CLK),
    .RST     (RST),
    .bus_if  (bus.slave),
    .state_o (dbg_state)
  );

  // External shifter: rotate implemented with a doubled-word shift.
  function automatic logic [WIDTH-1:0] shifter_fn(logic [WIDTH-1:0] d, logic [AMT_W-1:0] a, logic dir);
    logic [2*WIDTH-1:0] t;
    t = {d, d};
    if (dir == DIR_RIGHT) begin
      t = t >> a;
      return t[WIDTH-1:0];
    end
    t = t << a;
    return t[2*WIDTH-1:WIDTH];
  endfunction
  assign bus.sh_res = shifter_fn(bus.sh_data, bus.sh_amt, bus.sh_dir);

  // Model rotate written as bit-index arithmetic.
  function automatic logic [WIDTH-1:0] model_rot(logic [WIDTH-1:0] d, int a, logic dir);
    logic [WIDTH-1:0] o;
    o = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (dir == DIR_LEFT) o[(i + a) % WIDTH] = d[i];
      else                 o[i] = d[(i + a) % WIDTH];
    end
    return o;
  endfunction

  // ---------------- transaction model ----------------
  int               m_age;   // 0 idle, 1 grant cycle, 2 done cycle
  logic             m_sel, m_prio;
  logic [WIDTH-1:0] m_res, m_sh_data;
  logic [AMT_W-1:0] m_sh_amt;
  logic             m_sh_dir;
  logic [WIDTH-1:0] exp_q[$];

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      m_age = 0; m_sel = 0; m_prio = 0; m_res = '0;
      m_sh_data = '0; m_sh_amt = '0; m_sh_dir = 0;
      exp_q.delete();
    end else if (m_age == 0) begin
      if (bus.req0 || bus.req1) begin
        m_sel = (bus.req0 && bus.req1) ? m_prio : bus.req1;
        m_sh_data = m_sel ? bus.data1 : bus.data0;
        m_sh_amt  = m_sel ? bus.amt1  : bus.amt0;
        m_sh_dir  = m_sel ? bus.dir1  : bus.dir0;
        exp_q.push_back(model_rot(m_sh_data, int'(m_sh_amt), m_sh_dir));
        m_age = 1;
      end
    end else if (m_age == 1) begin
      m_res = model_rot(m_sh_data, int'(m_sh_amt), m_sh_dir);
      m_age = 2;
    end else begin
      m_prio = !m_sel;
      m_age = 0;
    end
  end

  // ---------------- scoreboard / checks ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic compare_all();
    state_e exp_state;
    exp_state = (m_age == 0) ? IDLE : (m_age == 1) ? EXEC : RESP;
    check("gnt0",    32'(bus.gnt0),  32'(m_age == 1 && !m_sel));
    check("gnt1",    32'(bus.gnt1),  32'(m_age == 1 &&  m_sel));
    check("done0",   32'(bus.done0), 32'(m_age == 2 && !m_sel));
    check("done1",   32'(bus.done1), 32'(m_age == 2 &&  m_sel));
    check("busy",    32'(bus.busy),  32'(m_age != 0));
    check("res",     32'(bus.res),     32'(m_res));
    check("sh_data", 32'(bus.sh_data), 32'(m_sh_data));
    check("sh_amt",  32'(bus.sh_amt),  32'(m_sh_amt));
    check("sh_dir",  32'(bus.sh_dir),  32'(m_sh_dir));
    check("state",   32'(dbg_state),   32'(exp_state));
    if (bus.done0 || bus.done1) begin
      if (exp_q.size() == 0) check("sb_unexpected_done", 32'(1), 32'(0));
      else check("sb_res", 32'(bus.res), 32'(exp_q.pop_front()));
    end
  endtask

  task automatic tick();
    @(negedge CLK);
    compare_all();
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_req(int idx, logic [WIDTH-1:0] d, logic [AMT_W-1:0] a, logic dir);
    if (idx == 0) begin bus.req0 = 1; bus.data0 = d; bus.amt0 = a; bus.dir0 = dir; end
    else          begin bus.req1 = 1; bus.data1 = d; bus.amt1 = a; bus.dir1 = dir; end
  endtask

  task automatic drop_req(int idx);
    if (idx == 0) bus.req0 = 0;
    else          bus.req1 = 0;
  endtask

  task automatic rand_req(int idx);
    drive_req(idx, WIDTH'($urandom), AMT_W'($urandom), 1'($urandom));
  endtask

  task automatic rand_drive();
    if (bus.gnt0) begin
      if ($urandom_range(0, 1) == 0) drop_req(0); else rand_req(0);
    end else if (!bus.req0 && $urandom_range(0, 2) == 0) rand_req(0);
    if (bus.gnt1) begin
      if ($urandom_range(0, 1) == 0) drop_req(1); else rand_req(1);
    end else if (!bus.req1 && $urandom_range(0, 2) == 0) rand_req(1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bus.req0 = 0; bus.req1 = 0;
    bus.data0 = '0; bus.data1 = '0; bus.amt0 = '0; bus.amt1 = '0;
    bus.dir0 = 0; bus.dir1 = 0;

    // Reset with random requests present
    #2 RST = 1;
    rand_req(0); rand_req(1);
    tick();
    tick();
    check("rst_gnt",   32'({bus.gnt1, bus.gnt0}), 32'(0));
    check("rst_done",  32'({bus.done1, bus.done0}), 32'(0));
    check("rst_busy",  32'(bus.busy), 32'(0));
    check("rst_res",   32'(bus.res), 32'(0));
    check("rst_sh",    32'({bus.sh_data, bus.sh_amt, bus.sh_dir}), 32'(0));
    drop_req(0); drop_req(1);
    RST = 0;
    tick();
    check("rst_state", 32'(dbg_state), 32'(IDLE));

    // Single request
    drive_req(0, 4'b1001, 2'd1, DIR_LEFT);
    tick();
    check("single_gnt0", 32'(bus.gnt0), 32'(1));
    check("single_gnt1", 32'(bus.gnt1), 32'(0));
    drop_req(0);
    tick();
    check("single_done0", 32'(bus.done0), 32'(1));
    check("single_res",   32'(bus.res), 32'(4'b0011));
    tick();

    // Simultaneous requests from reset, held for alternation
    RST = 1;
    tick();
    RST = 0;
    drive_req(0, 4'b0110, 2'd3, DIR_RIGHT);
    drive_req(1, 4'b1000, 2'd2, DIR_RIGHT);
    tick();
    check("both_gnt0_first", 32'({bus.gnt1, bus.gnt0}), 32'(2'b01));
    tick();
    check("both_res0", 32'(bus.res), 32'(4'b1100));
    tick();
    check("both_idle_gap", 32'(bus.busy), 32'(0));
    tick();
    check("both_gnt1", 32'({bus.gnt1, bus.gnt0}), 32'(2'b10));
    tick();
    check("both_done1", 32'(bus.done1), 32'(1));
    check("both_res1",  32'(bus.res), 32'(4'b0010));
    tick();
    tick();
    check("both_gnt0_again", 32'({bus.gnt1, bus.gnt0}), 32'(2'b01));
    drop_req(0); drop_req(1);
    tick();
    tick();

    // Late request rising during EXEC
    drive_req(0, 4'b0101, 2'd2, DIR_LEFT);
    tick();
    check("late_gnt0", 32'(bus.gnt0), 32'(1));
    drop_req(0);
    drive_req(1, 4'b0011, 2'd1, DIR_RIGHT);
    tick();
    check("late_no_gnt1_resp", 32'(bus.gnt1), 32'(0));
    tick();
    check("late_no_gnt1_idle", 32'({bus.gnt1, bus.busy}), 32'(0));
    tick();
    check("late_gnt1", 32'(bus.gnt1), 32'(1));
    drop_req(1);
    tick();
    check("late_res", 32'(bus.res), 32'(4'b1001));
    tick();

    // Reset during EXEC
    drive_req(0, 4'b1110, 2'd1, DIR_LEFT);
    tick();
    check("abort_gnt0", 32'(bus.gnt0), 32'(1));
    drop_req(0);
    RST = 1;
    #1;
    check("abort_async_busy", 32'(bus.busy), 32'(0));
    check("abort_async_res",  32'(bus.res), 32'(0));
    tick();
    RST = 0;
    tick();
    check("abort_no_done", 32'({bus.done1, bus.done0}), 32'(0));
    check("abort_res",     32'(bus.res), 32'(0));
    drive_req(0, 4'b1110, 2'd1, DIR_LEFT);
    tick();
    drop_req(0);
    tick();
    check("fresh_done0", 32'(bus.done0), 32'(1));
    check("fresh_res",   32'(bus.res), 32'(4'b1101));

    // Hold across idle cycles
    for (int i = 0; i < 10; i++) begin
      tick();
      check("hold_res", 32'(bus.res), 32'(4'b1101));
      check("hold_sh",  32'({bus.sh_data, bus.sh_amt, bus.sh_dir}), 32'({4'b1110, 2'd1, 1'b0}));
    end

    // Randomized traffic with occasional asynchronous resets
    for (int c = 0; c < 2000; c++) begin
      tick();
      if (RST) RST = 0;
      else if ($urandom_range(0, 299) == 0) RST = 1;
      rand_drive();
    end
    RST = 0;
    drop_req(0); drop_req(1);
    for (int i = 0; i < 6; i++) tick();
    check("sb_drained", 32'(exp_q.size()), 32'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/shift_arbiter.md
# shift_arbiter

Sequencing controller that shares one combinational barrel shifter between two requesters. A round-robin arbiter selects a requester, and the selected operands are loaded into registered shifter-input registers. The block captures the shifter result one cycle later and returns it with a one-cycle done pulse. It sits between the two client blocks and the shifter datapath, which is instantiated outside the block and connected through the sh_* ports.

## Interface
- WIDTH, 4, data width of shifter operand and result
- AMT_W, 2, shift-amount width; equals log2(WIDTH)
- CLK  input  1  clock, rising edge
- RST  input  1  reset, asynchronous, active-high
- req0 / req1  input  1  request from requester 0 / 1; held high until matching gnt
- data0 / data1  input  WIDTH  operand; stable while req high
- amt0 / amt1  input  AMT_W  shift amount; stable while req high
- dir0 / dir1  input  1  direction, 0 = left, 1 = right; stable while req high
- gnt0 / gnt1  output  1  one-cycle grant: operands accepted
- done0 / done1  output  1  one-cycle pulse: res valid for that requester
- res  output  WIDTH  captured shifter result; holds until next capture
- busy  output  1  high whenever state is not IDLE
- sh_data  output  WIDTH  registered operand to shifter
- sh_amt  output  AMT_W  registered amount to shifter
- sh_dir  output  1  registered direction to shifter
- sh_res  input  WIDTH  combinational shifter result

## Operation
- Moore FSM with 3 states: IDLE, EXEC, RESP. All outputs are registered or decoded from state.
- IDLE, no request pending: stay in IDLE. All sh_* and res hold their values.
- IDLE, req0 or req1 high at a clock edge:
  - The arbiter picks the winner (sel), and the FSM moves to EXEC.
  - sh_data, sh_amt and sh_dir load the winner's operands.
- Arbitration:
  - Priority pointer prio resets to 0.
  - Only one request high: that requester wins.
  - Both requests high: the requester indicated by prio wins.
  - prio is set to the other requester on the edge that leaves RESP.
- EXEC: gnt[sel] is high for exactly this cycle. On the next edge, res loads sh_res and the FSM moves to RESP.
- RESP: done[sel] is high for exactly this cycle. On the next edge, the FSM moves to IDLE.
- A request that stays high after gnt is treated as a new operation when the FSM is next in IDLE.
- A request that rises during EXEC or RESP waits; it is not lost and not accepted early.
- At most one of gnt0/gnt1, and at most one of done0/done1, is ever high.
- Reset values: state IDLE, prio 0, gnt0 = gnt1 = done0 = done1 = 0, busy 0, res 0, sh_data 0, sh_amt 0, sh_dir 0.
- RST asserted mid-operation:
  - The operation is aborted immediately (asynchronous), and no done pulse is issued for it.
  - After release, the first arbitration uses prio = 0.

## Timing
- Request sampled at edge k (FSM in IDLE): gnt during cycle k..k+1, done and new res during cycle k+1..k+2.
- Latency from request acceptance to done: 2 cycles.
- Throughput: one operation per 3 cycles. Back-to-back alternating service when both requesters are held high.
- sh_* are stable from edge k through edge k+1. The shifter has a full cycle to settle before capture.
- res changes only on the EXEC→RESP edge.

## Structure
- Shared package shift_pkg:
  - state enum: IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2
  - direction constants: DIR_LEFT = 0, DIR_RIGHT = 1
- One sub-module, rr_arb2: 2-input round-robin arbiter.
  - Inputs: req[1:0], prio, en.
  - Outputs: sel, valid.
- The FSM, operand registers and result register live in shift_arbiter.

## Test plan
The bench models sh_res as a rotate of sh_data by sh_amt in direction sh_dir.

- Reset check: RST pulse with random inputs → all outputs 0, busy 0; state IDLE after release.
- Single request: req0 with data0 = 4'b1001, amt0 = 1, dir0 = 0 at edge k → gnt0 in cycle k+1, done0 in cycle k+2, res = 4'b0011. gnt1 and done1 stay 0.
- Simultaneous requests from reset: both high, req1 with data1 = 4'b1000, amt1 = 2, dir1 = 1 →
  - req0 served first.
  - Then req1 is served, with its gnt1 3 cycles after gnt0 and res = 4'b0010.
  - Alternation continues while both are held high.
- Late request: req1 rises during EXEC of a req0 operation → no gnt1 until the FSM returns to IDLE. req1 is then granted on the next edge, with no lost request.
- Reset mid-operation: RST asserted during EXEC → done never pulses, and res = 0. A fresh req0 after release completes normally with correct res.
- Hold check: res and sh_* remain unchanged across 10 idle cycles after the last done.
